iq_join: RTL

- Recombines two independent AXI-stream lanes, I and Q, into one paired I/Q stream. It is the inverse of the I/Q split stage.
- Sits upstream of the splitter and of the paired-sample DSP stages. It feeds them from separately produced I and Q sources.
- Each lane has a small FIFO that absorbs inter-lane skew. A registered output stage emits a beat only when both lanes hold a sample.

---
 rtl/iq_join_pkg.sv | 13 +
 rtl/iq_lane_fifo.sv | 76 +++++++
 rtl/iq_join.sv | 88 ++++++++
 3 files changed

// File: rtl/iq_join_pkg.sv
// Shared helpers for the I/Q join block: address-width derivation for the lane FIFOs.
package iq_join_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/iq_lane_fifo.sv
// Per-lane skew FIFO: AXI-style write handshake with registered ready, pop strobe,
// head-of-queue data and occupancy count for the pairing logic.
module iq_lane_fifo
  import iq_join_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  head_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0]   FULL    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ready_q, ready_d;
  logic              wr;

  assign wr = wr_valid_i && ready_q;

  // Ready looks at next-cycle occupancy, so a write into the last slot closes the lane in time.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (wr && !pop_i) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr && pop_i) begin
      count_d = count_q - CNT_ONE;
    end
    ready_d = (count_d < FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign wr_ready_o = ready_q;
  assign head_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/iq_join.sv
// Joins independent I and Q AXI-stream lanes into one paired stream; each lane is
// buffered in a skew FIFO and a pair is emitted only when both lanes hold a sample.
module iq_join
  import iq_join_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_i_tdata,
  input  logic             input_i_tvalid,
  output logic             input_i_tready,
  input  logic [WIDTH-1:0] input_q_tdata,
  input  logic             input_q_tvalid,
  output logic             input_q_tready,
  output logic [WIDTH-1:0] output_i_tdata,
  output logic [WIDTH-1:0] output_q_tdata,
  output logic             output_tvalid,
  input  logic             output_tready
);

  localparam int ADDR_W = clog2(DEPTH);

  logic [ADDR_W:0]  count_i, count_q;
  logic [WIDTH-1:0] head_i, head_q;
  logic             pair_avail;
  logic             load;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_i_q, out_i_d;
  logic [WIDTH-1:0] out_q_q, out_q_d;

  iq_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_i (
    .clk        (clk),
    .rst_n      (rst),
    .wr_data_i  (input_i_tdata),
    .wr_valid_i (input_i_tvalid),
    .wr_ready_o (input_i_tready),
    .pop_i      (load),
    .head_o     (head_i),
    .count_o    (count_i)
  );

  iq_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_q (
    .clk        (clk),
    .rst_n      (rst),
    .wr_data_i  (input_q_tdata),
    .wr_valid_i (input_q_tvalid),
    .wr_ready_o (input_q_tready),
    .pop_i      (load),
    .head_o     (head_q),
    .count_o    (count_q)
  );

  // Both lanes pop together so pairing stays strictly by per-lane arrival order.
  assign pair_avail = (count_i != '0) && (count_q != '0);
  assign load       = pair_avail && (!out_valid_q || output_tready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_i_d     = head_i;
      out_q_d     = head_q;
    end else if (output_tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
    end
  end

  assign output_tvalid  = out_valid_q;
  assign output_i_tdata = out_i_q;
  assign output_q_tdata = out_q_q;

endmodule
